// File: rtl/uart_pkg.sv
// UART transmit framer shared definitions.
// FSM states and break-length constants, reused by the receive side.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK,
        ST_MARK
    } state_t;

    localparam int unsigned BRK_N0        = 2;
    localparam int unsigned BRK_N1        = 4;
    localparam int unsigned BRK_N2        = 8;
    localparam int unsigned BRK_N3        = 16;
    localparam int unsigned BITS_PER_CHAR = 12;
    localparam int unsigned BRK_MAX       = (BRK_N3 + 1) * BITS_PER_CHAR;

    // Break length in bit periods: (N+1) characters of 12 bits.
    function automatic logic [7:0] brk_periods(input logic [1:0] lvl);
        int unsigned n;
        n = BRK_N0;
        case (lvl)
            2'd0: n = BRK_N0;
            2'd1: n = BRK_N1;
            2'd2: n = BRK_N2;
            2'd3: n = BRK_N3;
        endcase
        return 8'((n + 1) * BITS_PER_CHAR);
    endfunction

endpackage

// File: rtl/uart_nco.sv
// Baud x16 NCO: 17-bit accumulator, carry out is the x16 tick.
// Clear restarts the phase so a new frame gets exact bit lengths.
module uart_nco
    import uart_pkg::*;
#(
    parameter int NcoWidth = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_clr,
    input  logic [NcoWidth-1:0] i_inc,
    output logic                o_tick
);

    logic [NcoWidth:0] r_sum;

    // Accumulate the increment; the previous carry is dropped each step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= '0;
        end else if (!i_en) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= {1'b0, i_inc};
        end else begin
            r_sum <= {1'b0, r_sum[NcoWidth-1:0]} + {1'b0, i_inc};
        end
    end

    assign o_tick = r_sum[NcoWidth];

endmodule

// File: rtl/uart_tx_frm.sv
// UART transmit framer with parity/stop options, error injection
// and break generation; serial line and status are registered.
module uart_tx_frm
    import uart_pkg::*;
#(
    parameter int NcoWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tx_enable,
    input  logic [NcoWidth-1:0] nco_i,
    input  logic                parity_enable,
    input  logic                parity_odd,
    input  logic                stop2,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [7:0]          data_i,
    input  logic                err_parity_i,
    input  logic                err_frame_i,
    input  logic                break_req_i,
    input  logic [1:0]          break_lvl_i,
    output logic                tx_o,
    output logic                idle_o,
    output logic                break_done_o
);

    state_t      r_state;
    logic        r_tx;
    logic        r_idle;
    logic        r_done;
    logic [3:0]  r_sub;
    logic [2:0]  r_bit_cnt;
    logic        r_stop_cnt;
    logic [7:0]  r_brk_cnt;
    logic [7:0]  r_shift;
    logic        r_dpar;
    logic        r_errp;
    logic        r_errf;

    logic        w_tick;
    logic        w_bnd;
    logic        w_accept;
    logic        w_brk_go;
    logic        w_par;
    logic        w_nco_clr;

    // Phase is held cleared in IDLE so every frame starts aligned.
    assign w_nco_clr = (r_state == ST_IDLE);

    uart_nco #(
        .NcoWidth (NcoWidth)
    ) u_nco (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_en    (tx_enable),
        .i_clr   (w_nco_clr),
        .i_inc   (nco_i),
        .o_tick  (w_tick)
    );

    assign ready_o  = (r_state == ST_IDLE) & tx_enable & ~break_req_i;
    assign w_accept = valid_i & ready_o;
    assign w_brk_go = (r_state == ST_IDLE) & tx_enable & break_req_i;
    assign w_bnd    = w_tick & (r_sub == 4'd15);
    assign w_par    = r_dpar ^ parity_odd ^ r_errp;

    assign tx_o         = r_tx;
    assign idle_o       = r_idle;
    assign break_done_o = r_done;

    // Frame/break sequencer; all line and status outputs registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_idle     <= 1'b1;
            r_done     <= 1'b0;
            r_sub      <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_brk_cnt  <= '0;
            r_shift    <= '0;
            r_dpar     <= 1'b0;
            r_errp     <= 1'b0;
            r_errf     <= 1'b0;
        end else if (r_state != ST_IDLE && !tx_enable) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_idle     <= 1'b1;
            r_done     <= 1'b0;
            r_sub      <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_brk_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_tick) begin
                r_sub <= r_sub + 4'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_sub <= '0;
                    if (w_brk_go) begin
                        r_state   <= ST_BREAK;
                        r_tx      <= 1'b0;
                        r_idle    <= 1'b0;
                        r_brk_cnt <= brk_periods(break_lvl_i) - 8'd1;
                    end else if (w_accept) begin
                        r_state   <= ST_START;
                        r_tx      <= 1'b0;
                        r_idle    <= 1'b0;
                        r_shift   <= data_i;
                        r_dpar    <= ^data_i;
                        r_errp    <= err_parity_i;
                        r_errf    <= err_frame_i;
                        r_bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (w_bnd) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end
                end
                ST_DATA: begin
                    if (w_bnd) begin
                        if (r_bit_cnt == 3'd7) begin
                            if (parity_enable) begin
                                r_state <= ST_PARITY;
                                r_tx    <= w_par;
                            end else begin
                                r_state    <= ST_STOP;
                                r_tx       <= ~r_errf;
                                r_stop_cnt <= 1'b0;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bnd) begin
                        r_state    <= ST_STOP;
                        r_tx       <= ~r_errf;
                        r_stop_cnt <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (w_bnd) begin
                        if (stop2 && !r_stop_cnt) begin
                            r_stop_cnt <= 1'b1;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_tx       <= 1'b1;
                            r_idle     <= 1'b1;
                            r_stop_cnt <= 1'b0;
                        end
                    end
                end
                ST_BREAK: begin
                    if (w_bnd) begin
                        if (r_brk_cnt == 8'd0) begin
                            r_state <= ST_MARK;
                            r_tx    <= 1'b1;
                        end else begin
                            r_brk_cnt <= r_brk_cnt - 8'd1;
                        end
                    end
                end
                ST_MARK: begin
                    if (w_bnd) begin
                        r_state <= ST_IDLE;
                        r_idle  <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule
